// File: rtl/keypad_lockout.sv
// keypad_lockout: supervisor that gates the keypad enable, times out wrong entries
// and latches an alarm after MAXF consecutive failures.
module keypad_lockout #(
    parameter int MAXF    = 3,
    parameter int LOCKCYC = 8,
    parameter int FW      = $clog2(MAXF + 1),
    parameter int PW      = $clog2(LOCKCYC + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RSTI,
    input  logic          ULKI,
    input  logic          ACKN,
    input  logic          RELK,
    output logic          ENBL,
    output logic          OPEN,
    output logic          ALRM,
    output logic [FW-1:0] FCNT,
    output logic [PW-1:0] PCNT,
    output logic [1:0]    ostate
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENALTY = 2'd1,
        S_ALARM   = 2'd2,
        S_OPEN    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          rsti_q, ulki_q;
    logic          fail_ev, ok_ev;

    assign fail_ev = RSTI & ~rsti_q;
    assign ok_ev   = ULKI & ~ulki_q;

    // previous-value registers reset high so inputs held through reset never fire
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            pcnt_q  <= '0;
            rsti_q  <= 1'b1;
            ulki_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pcnt_q  <= pcnt_d;
            rsti_q  <= RSTI;
            ulki_q  <= ULKI;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            S_IDLE: begin
                if (fail_ev) begin
                    fcnt_d = fcnt_q + 1'b1;
                    if (fcnt_q == FW'(MAXF - 1)) begin
                        state_d = S_ALARM;
                    end else begin
                        state_d = S_PENALTY;
                        pcnt_d  = PW'(LOCKCYC);
                    end
                end else if (ok_ev) begin
                    fcnt_d  = '0;
                    state_d = S_OPEN;
                end
            end
            S_PENALTY: begin
                pcnt_d = pcnt_q - 1'b1;
                if (pcnt_q == PW'(1)) state_d = S_IDLE;
            end
            S_ALARM: begin
                if (ACKN) begin
                    fcnt_d  = '0;
                    state_d = S_IDLE;
                end
            end
            S_OPEN: begin
                if (RELK) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                pcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        ENBL   = state_q == S_IDLE;
        OPEN   = state_q == S_OPEN;
        ALRM   = state_q == S_ALARM;
        FCNT   = fcnt_q;
        PCNT   = pcnt_q;
        ostate = state_q;
    end
endmodule

// File: tb/tb_keypad_lockout.sv
// tb_keypad_lockout: directed checks of the lockout supervisor with MAXF=3, LOCKCYC=4.
module tb_keypad_lockout;
    localparam int MAXF    = 3;
    localparam int LOCKCYC = 4;
    localparam int FW      = $clog2(MAXF + 1);
    localparam int PW      = $clog2(LOCKCYC + 1);

    logic          CLK = 1'b0;
    logic          RST = 1'b0, RSTI = 1'b0, ULKI = 1'b0, ACKN = 1'b0, RELK = 1'b0;
    logic          ENBL, OPEN, ALRM;
    logic [FW-1:0] FCNT;
    logic [PW-1:0] PCNT;
    logic [1:0]    ostate;
    int            checks = 0;
    int            errors = 0;
    int            enbl_low;

    keypad_lockout #(.MAXF(MAXF), .LOCKCYC(LOCKCYC)) dut (
        .CLK(CLK), .RST(RST), .RSTI(RSTI), .ULKI(ULKI), .ACKN(ACKN), .RELK(RELK),
        .ENBL(ENBL), .OPEN(OPEN), .ALRM(ALRM), .FCNT(FCNT), .PCNT(PCNT), .ostate(ostate)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int en, input int op,
                           input int al, input int fc, input int pc);
        chk({tag, ".ostate"}, 32'(ostate), 32'(st));
        chk({tag, ".ENBL"}, 32'(ENBL), 32'(en));
        chk({tag, ".OPEN"}, 32'(OPEN), 32'(op));
        chk({tag, ".ALRM"}, 32'(ALRM), 32'(al));
        chk({tag, ".FCNT"}, 32'(FCNT), 32'(fc));
        chk({tag, ".PCNT"}, 32'(PCNT), 32'(pc));
    endtask

    task automatic do_reset();
        RST = 1'b1; RSTI = 1'b0; ULKI = 1'b0; ACKN = 1'b0; RELK = 1'b0;
        step();
        RST = 1'b0;
        step();
    endtask

    initial begin
        // Test 1: reset with inputs held high, no event afterwards
        RST = 1'b1; RSTI = 1'b1; ULKI = 1'b1;
        step();
        step();
        chk_all("t1_rst", 0, 1, 0, 0, 0, 0);
        RST = 1'b0;
        step();
        chk_all("t1_rel", 0, 1, 0, 0, 0, 0);
        step();
        chk_all("t1_hold", 0, 1, 0, 0, 0, 0);

        // Test 2: unlock then relock
        ULKI = 1'b0; RSTI = 1'b0;
        step();
        ULKI = 1'b1;
        step();
        chk_all("t2_open", 3, 0, 1, 0, 0, 0);
        ULKI = 1'b0; RSTI = 1'b1;
        step();
        chk_all("t2_ign", 3, 0, 1, 0, 0, 0);
        RSTI = 1'b0; RELK = 1'b1;
        step();
        RELK = 1'b0;
        chk_all("t2_relk", 0, 1, 0, 0, 0, 0);

        // Test 3: RSTI held for 3 cycles counts once, penalty lasts LOCKCYC cycles
        step();
        RSTI = 1'b1;
        step();
        enbl_low = 0;
        for (int i = 0; i < LOCKCYC; i++) begin
            chk_all($sformatf("t3_pen%0d", i), 1, 0, 0, 0, 1, LOCKCYC - i);
            if (!ENBL) enbl_low++;
            if (i == 2) RSTI = 1'b0;
            step();
        end
        chk("t3_enbl_low", 32'(enbl_low), 32'(LOCKCYC));
        chk_all("t3_idle", 0, 1, 0, 0, 1, 0);

        // Test 4: three failures latch the alarm; only ACKN clears it
        do_reset();
        for (int k = 1; k <= MAXF; k++) begin
            RSTI = 1'b1;
            step();
            RSTI = 1'b0;
            if (k < MAXF) begin
                chk_all($sformatf("t4_fail%0d", k), 1, 0, 0, 0, k, LOCKCYC);
                repeat (LOCKCYC) step();
                chk_all($sformatf("t4_back%0d", k), 0, 1, 0, 0, k, 0);
            end else begin
                chk_all("t4_alarm", 2, 0, 0, 1, MAXF, 0);
            end
        end
        RSTI = 1'b1; ULKI = 1'b1; RELK = 1'b1;
        step();
        RSTI = 1'b0; ULKI = 1'b0; RELK = 1'b0;
        step();
        repeat (5) step();
        chk_all("t4_persist", 2, 0, 0, 1, MAXF, 0);
        ACKN = 1'b1;
        step();
        ACKN = 1'b0;
        chk_all("t4_ackn", 0, 1, 0, 0, 0, 0);

        // Test 5: simultaneous edges, fail wins; edges during penalty ignored
        step();
        RSTI = 1'b1; ULKI = 1'b1;
        step();
        chk_all("t5_both", 1, 0, 0, 0, 1, LOCKCYC);
        RSTI = 1'b0; ULKI = 1'b0;
        step();
        RSTI = 1'b1;
        step();
        chk_all("t5_ignore", 1, 0, 0, 0, 1, 2);

        // Test 6: reset mid-penalty (PCNT=2) and mid-alarm
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_all("t6_rst_pen", 0, 1, 0, 0, 0, 0);
        step();
        chk_all("t6_no_ev", 0, 1, 0, 0, 0, 0);
        RSTI = 1'b0;
        step();
        for (int k = 1; k < MAXF; k++) begin
            RSTI = 1'b1;
            step();
            RSTI = 1'b0;
            repeat (LOCKCYC) step();
        end
        RSTI = 1'b1;
        step();
        RSTI = 1'b0;
        chk_all("t6_alarm", 2, 0, 0, 1, MAXF, 0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_all("t6_rst_alm", 0, 1, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_lockout.md
Name: keypad_lockout

Overview:
- Downstream supervisor for the keypad FSM. Consumes the keypad's RSTO (bad-combination reset) and ULCK (unlocked) outputs.
- Enforces a timed penalty after each wrong entry and latches an alarm after MAXF consecutive failures.
- Drives the keypad's ENBL input, so the keypad only accepts button presses while the supervisor is armed.
- Exposes open, alarm, failure-count and penalty-count status for the LED/display stage.

Parameters:
MAXF, 3, consecutive failures that trigger ALARM (MAXF >= 1)
LOCKCYC, 8, penalty length in CLK cycles with ENBL low (LOCKCYC >= 1)
FW, $clog2(MAXF+1), width of failure counter (derived)
PW, $clog2(LOCKCYC+1), width of penalty counter (derived)

Ports:
CLK   input   1    system clock, all state updates on rising edge
RST   input   1    synchronous, active-high reset
RSTI  input   1    keypad RSTO: wrong combination entered (level; may stay high several cycles)
ULKI  input   1    keypad ULCK: correct combination entered (level)
ACKN  input   1    supervisor acknowledge; clears ALARM
RELK  input   1    relock request; leaves OPEN
ENBL  output  1    enable to keypad; 1 only in IDLE
OPEN  output  1    safe open (state OPEN)
ALRM  output  1    alarm latched (state ALARM)
FCNT  output  FW   consecutive failures so far
PCNT  output  PW   penalty cycles remaining
ostate output 2    state code: IDLE=0, PENALTY=1, ALARM=2, OPEN=3

Behaviour:
- Reset: clocking CLK with RST=1 yields state IDLE, ENBL=1, OPEN=0, ALRM=0, FCNT=0, PCNT=0.
- RST has priority over every other input.
- Edge detect: rsti_q and ulki_q register the previous RSTI and ULKI values.
  - Both registers reset to 1, so an input held high through reset never produces an event.
  - fail_ev = RSTI & ~rsti_q; ok_ev = ULKI & ~ulki_q.
  - The previous-value registers update every cycle in every state.
- All outputs are registered. A change is visible the cycle after the triggering edge (1-cycle latency).
- IDLE:
  - ENBL=1.
  - fail_ev present: FCNT <= FCNT+1.
    - If FCNT+1 == MAXF: go to ALARM.
    - Otherwise: go to PENALTY with PCNT <= LOCKCYC.
  - ok_ev present without fail_ev: FCNT <= 0, go to OPEN.
  - fail_ev and ok_ev in the same cycle: fail_ev wins.
- PENALTY:
  - ENBL=0.
  - PCNT decrements by 1 each cycle.
  - When PCNT==1: next state IDLE, PCNT <= 0.
  - ENBL is therefore low for exactly LOCKCYC cycles.
  - fail_ev, ok_ev, ACKN and RELK are ignored.
- ALARM:
  - ENBL=0, ALRM=1, FCNT holds MAXF, PCNT=0.
  - ACKN=1: FCNT <= 0, next state IDLE.
  - Events and RELK are ignored.
  - ALARM persists indefinitely without ACKN.
- OPEN:
  - ENBL=0, OPEN=1.
  - RELK=1: next state IDLE; FCNT stays 0.
  - Events and ACKN are ignored.
- Counters:
  - FCNT saturates at MAXF and never wraps.
  - FCNT clears only on ok_ev in IDLE, on ACKN in ALARM, or on RST.
  - PCNT never underflows; it is 0 in every state except PENALTY.
- Reset mid-PENALTY or mid-ALARM returns to IDLE immediately, with counters cleared.
- Unused state encodings (none with 2 bits) are not applicable. Default branch goes to IDLE.

Test Plan:
- Test 1 (MAXF=3, LOCKCYC=4): RST for 2 cycles with RSTI=ULKI=1, then release -> IDLE, ENBL=1, FCNT=0, no event fires while the inputs stay high.
- Test 2: ULKI 0->1 in IDLE -> next cycle ostate=3, OPEN=1, ENBL=0, FCNT=0; RELK pulse -> next cycle ostate=0, ENBL=1.
- Test 3: RSTI 0->1, held 3 cycles -> FCNT=1, ostate=1, PCNT=4,3,2,1 on successive cycles, then ostate=0, ENBL=1. Exactly 4 cycles with ENBL=0 and only one failure counted.
- Test 4: three separate RSTI rising edges, each after its penalty expires -> FCNT=1,2,3; after the third, ostate=2, ALRM=1, ENBL=0. RSTI/ULKI/RELK pulses are ignored; ACKN -> IDLE, FCNT=0.
- Test 5: in IDLE, RSTI and ULKI rise in the same cycle -> PENALTY, FCNT=1, OPEN stays 0. RSTI edge arriving during PENALTY -> FCNT unchanged.
- Test 6: assert RST while PCNT=2 in PENALTY, and again in ALARM -> next cycle ostate=0, ENBL=1, FCNT=0, PCNT=0, ALRM=0.
